store_byte_serializer: RTL

//  Narrowing counterpart of the 12->32 sign extender: takes a 32-bit store operand plus

---
 rtl/store_byte_serializer_pkg.sv | 33 +++
 rtl/store_byte_serializer_if.sv | 26 ++
 rtl/store_byte_serializer_byte_lane_select.sv | 17 +
 rtl/store_byte_serializer.sv | 110 +++++++++++
 4 files changed

// File: rtl/store_byte_serializer_pkg.sv
// Shared definitions for the store byte serializer: store-size codes, FSM states
// and small decode helpers used by the top level.
package store_byte_serializer_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RESP
  } state_t;

  // Index of the final beat (N-1), kept in 2 bits so N=4 never needs a third bit.
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SIZE_B:  last_beat = 2'd0;
      SIZE_H:  last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  endfunction

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_B:  req_bad = 1'b0;
      SIZE_H:  req_bad = lsb[0];
      SIZE_W:  req_bad = (lsb != 2'b00);
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_byte_serializer_if.sv
// Request and byte-wide memory bus of the store byte serializer.
interface store_byte_serializer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_data;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_data, req_addr, req_size, mem_ack,
    input  req_ready, mem_we, mem_addr, mem_wdata, done, err
  );

  modport slave (
    input  req_valid, req_data, req_addr, req_size, mem_ack,
    output req_ready, mem_we, mem_addr, mem_wdata, done, err
  );
endinterface

// File: rtl/store_byte_serializer_byte_lane_select.sv
// Picks byte lane idx (little-endian) out of a 32-bit word; purely combinational.
module byte_lane_select (
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  output logic [7:0]  lane
);
  always_comb begin
    lane = '0;
    case (idx)
      2'd0: lane = word[7:0];
      2'd1: lane = word[15:8];
      2'd2: lane = word[23:16];
      2'd3: lane = word[31:24];
      default: lane = '0;
    endcase
  end
endmodule

// File: rtl/store_byte_serializer.sv
// Serializes an SB/SH/SW store operand onto a byte-wide memory port, one acked
// beat at a time, little-endian, with alignment checking and per-beat timeout.
module store_byte_serializer
  import store_byte_serializer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  store_byte_serializer_if.slave   bus
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        last_q;
  logic [1:0]        beat;
  logic [TW-1:0]     tcnt;

  logic [31:0]       lane_word;
  logic [1:0]        lane_idx;
  logic [7:0]        lane_byte;
  logic              timed_out;

  // The lane mux looks one beat ahead so mem_wdata can be registered with mem_addr.
  always_comb begin
    lane_word = data_q;
    lane_idx  = beat + 2'd1;
    if (state == ST_IDLE) begin
      lane_word = bus.req_data;
      lane_idx  = '0;
    end
  end

  byte_lane_select u_lane (
    .word (lane_word),
    .idx  (lane_idx),
    .lane (lane_byte)
  );

  assign bus.req_ready = (state == ST_IDLE);
  assign timed_out     = (TIMEOUT != 0) && (tcnt == TLAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      data_q        <= '0;
      addr_q        <= '0;
      last_q        <= '0;
      beat          <= '0;
      tcnt          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            data_q <= bus.req_data;
            addr_q <= bus.req_addr;
            last_q <= last_beat(bus.req_size);
            beat   <= '0;
            tcnt   <= '0;
            if (req_bad(bus.req_size, bus.req_addr[1:0])) begin
              bus.err <= 1'b1;
              state   <= ST_RESP;
            end else begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= bus.req_addr;
              bus.mem_wdata <= lane_byte;
              state         <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          // An ack in the final timeout cycle still completes the beat.
          if (bus.mem_ack) begin
            tcnt <= '0;
            if (beat == last_q) begin
              bus.mem_we <= 1'b0;
              bus.done   <= 1'b1;
              state      <= ST_RESP;
            end else begin
              beat          <= beat + 2'd1;
              bus.mem_addr  <= {addr_q[ADDR_W-1:2], addr_q[1:0] + beat + 2'd1};
              bus.mem_wdata <= lane_byte;
            end
          end else if (timed_out) begin
            bus.mem_we <= 1'b0;
            bus.err    <= 1'b1;
            state      <= ST_RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
